// File: rtl/nv_fifo_pkg.sv
// Shared constants, types and counter helper for the 256x16 two-port-RAM FIFO.
// The read side is a two-stage pipeline in front of a registered-read RAM.
package nv_fifo_pkg;

  localparam int FIFO_DEPTH = 256;
  localparam int FIFO_AW    = 8;
  localparam int FIFO_DW    = 16;
  localparam int FIFO_CW    = 9;

  typedef logic [FIFO_AW-1:0] addr_t;
  typedef logic [FIFO_DW-1:0] data_t;
  typedef logic [FIFO_CW-1:0] cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);

  // Increment and decrement in the same cycle cancel out.
  function automatic cnt_t cnt_step(input cnt_t cnt, input logic inc, input logic dec);
    return cnt + cnt_t'(inc) - cnt_t'(dec);
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_256x16.sv
// 256x16 RAM with one write port and one read port.
// The read address is registered on re; the output register is loaded on ore.
module nv_ram_rwsp_256x16
  import nv_fifo_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] pwrbus_ram_pd,
  input  logic        re,
  input  addr_t       ra,
  input  logic        ore,
  output data_t       dout,
  input  logic        we,
  input  addr_t       wa,
  input  data_t       di
);

  data_t mem_q [FIFO_DEPTH];
  addr_t ra_q;
  data_t dout_q;

  // Power-control bus has no effect in this behavioural model.
  logic pwrbus_unused;
  assign pwrbus_unused = ^pwrbus_ram_pd;

  // NOTE: storage, read address and output register carry no reset; RAM
  // macros cannot be reset and the control side decides what is valid.
  always_ff @(posedge clk) begin
    if (we)  mem_q[wa] <= di;
    if (re)  ra_q      <= ra;
    if (ore) dout_q    <= mem_q[ra_q];
  end

  assign dout = dout_q;

endmodule

// File: rtl/nv_fifo_rwsp_256x16.sv
// 256x16 valid/ready FIFO: RAM storage, read issue stage S1 and output stage S2.
// wr_count covers every entry from accepted write until it is popped at rd_pd.
module nv_fifo_rwsp_256x16
  import nv_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  data_t       wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output data_t       rd_pd,
  output cnt_t        wr_count,
  input  logic [31:0] pwrbus_ram_pd
);

  addr_t wr_ptr_q, wr_ptr_d;
  addr_t rd_ptr_q, rd_ptr_d;
  cnt_t  wr_count_q, wr_count_d;
  cnt_t  ram_cnt_q, ram_cnt_d;
  logic  s1_vld_q, s1_vld_d;
  logic  rd_pvld_q, rd_pvld_d;
  logic  wr_prdy_q, wr_prdy_d;

  logic push, pop, adv2, iss;

  // NOTE: every signal assigned here gets a value on every path, so no latch.
  always_comb begin
    // wr_prdy_q is 1 during reset, so the write strobe must also see rst.
    push = wr_pvld & wr_prdy_q & ~rst;
    pop  = rd_pvld_q & rd_prdy;
    adv2 = s1_vld_q & (~rd_pvld_q | rd_prdy);
    iss  = (ram_cnt_q != '0) & (~s1_vld_q | adv2);

    wr_ptr_d   = wr_ptr_q + addr_t'(push);
    rd_ptr_d   = rd_ptr_q + addr_t'(iss);
    wr_count_d = cnt_step(wr_count_q, push, pop);
    ram_cnt_d  = cnt_step(ram_cnt_q, push, iss);
    wr_prdy_d  = (wr_count_d != CNT_FULL);
    s1_vld_d   = iss | (s1_vld_q & ~adv2);
    rd_pvld_d  = adv2 | (rd_pvld_q & ~rd_prdy);
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_count_q <= '0;
      ram_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      rd_pvld_q  <= 1'b0;
      wr_prdy_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_count_q <= wr_count_d;
      ram_cnt_q  <= ram_cnt_d;
      s1_vld_q   <= s1_vld_d;
      rd_pvld_q  <= rd_pvld_d;
      wr_prdy_q  <= wr_prdy_d;
    end
  end

  nv_ram_rwsp_256x16 u_ram (
    .clk           (clk),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .re            (iss),
    .ra            (rd_ptr_q),
    .ore           (adv2),
    .dout          (rd_pd),
    .we            (push),
    .wa            (wr_ptr_q),
    .di            (wr_pd)
  );

  assign wr_prdy  = wr_prdy_q;
  assign rd_pvld  = rd_pvld_q;
  assign wr_count = wr_count_q;

endmodule

// File: doc/nv_fifo_rwsp_256x16.md
NV_FIFO_RWSP_256X16 -- requirements
Module: nv_fifo_rwsp_256x16

Interface
REQ-001 SHALL have no parameters; depth 256 and width 16 are fixed.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: wr_pvld  input  1  write data valid.
REQ-005 SHALL have port: wr_prdy  output  1  write accept; registered.
REQ-006 SHALL have port: wr_pd  input  16  write payload.
REQ-007 SHALL have port: rd_pvld  output  1  read data valid; registered.
REQ-008 SHALL have port: rd_prdy  input  1  read data accept.
REQ-009 SHALL have port: rd_pd  output  16  read payload; the RAM output register drives it directly.
REQ-010 SHALL have port: wr_count  output  9  total occupancy, 0..256, counting RAM plus in-flight plus output entries.
REQ-011 SHALL have port: pwrbus_ram_pd  input  32  passed unchanged to the RAM.

Function
REQ-012 SHALL accept a write when wr_pvld&wr_prdy: drive we=1, wa=wr_ptr, di=wr_pd, and increment the 8-bit wr_ptr, wrapping 255->0.
REQ-013 SHALL drive wr_prdy = (next wr_count != 256), registered.
REQ-014 SHALL track ram_cnt (0..256) = entries written but not yet issued for read; the read side issues only when ram_cnt>0.
REQ-015 SHALL run a two-stage read pipeline. Stage S1 valid = address latched in the RAM (re pulsed the previous cycle). Stage S2 valid = rd_pvld.
REQ-016 SHALL advance S2 when adv2 = S1 & (!S2 | rd_prdy): assert ore=1 and set rd_pvld=1 next cycle.
REQ-017 SHALL issue a read when iss = (ram_cnt>0) & (!S1 | adv2): assert re=1, ra=rd_ptr, increment rd_ptr with wrap 255->0, and set S1 next cycle.
REQ-018 SHALL hold re=0 while S1 is stalled, so the RAM's registered read address stays stable and the data is preserved.
REQ-019 SHALL clear rd_pvld after rd_pvld&rd_prdy unless adv2 occurs in the same cycle; with rd_prdy held high the sustained throughput is 1 word/cycle.
REQ-020 SHALL have latency: a word written in cycle T, with the FIFO otherwise empty, is presented with rd_pvld=1 in cycle T+3 (re T+1, ore T+2).
REQ-021 SHALL decrement wr_count only on rd_pvld&rd_prdy, so an entry's RAM slot is never rewritten while its read is in flight.
REQ-022 SHALL apply push and pop in the same cycle as net-zero on wr_count; push and issue in the same cycle are net-zero on ram_cnt.
REQ-023 SHALL, when full (wr_count=256) with a pop this cycle, raise wr_prdy the following cycle and not the same cycle.
REQ-024 SHALL keep rd_pd stable while rd_pvld=1 and rd_prdy=0.
REQ-025 SHALL ignore wr_pd and wr_pvld when wr_prdy=0; no overflow is possible.

Reset
REQ-026 SHALL, on rst assertion at any time (including mid-transfer), immediately clear wr_ptr, rd_ptr, wr_count, ram_cnt, S1 and rd_pvld to 0, and set wr_prdy=1 on release.
REQ-027 SHALL leave RAM contents and rd_pd uninitialized by reset; rd_pd is undefined while rd_pvld=0.
REQ-028 SHALL hold re, we and ore low while rst is asserted; any in-flight data is discarded.

Structure
REQ-029 SHALL place constants FIFO_DEPTH=256, FIFO_AW=8, FIFO_DW=16 and FIFO_CW=9 in the shared package nv_fifo_pkg.
REQ-030 SHALL instantiate exactly one sub-module, nv_ram_rwsp_256x16, for storage; control logic stays in this module.

Verification
REQ-031 SHALL cover: single write 0xA5A5 in cycle 10 with rd_prdy=1 -> rd_pvld=1, rd_pd=0xA5A5 in cycle 13, then wr_count returns to 0.
REQ-032 SHALL cover: 256 back-to-back writes (data=index) with rd_prdy=0 -> wr_prdy=0 after the 256th, wr_count=256; a 257th write is not accepted.
REQ-033 SHALL cover: from full, one pop -> wr_prdy=1 exactly one cycle later; then continuous push/pop for 1000 cycles -> wr_count stays 256/255 and data stays in order.
REQ-034 SHALL cover: streaming 600 words with a random rd_prdy stall pattern -> in-order output, no loss or duplication, rd_pd stable during stalls, pointers wrap correctly.
REQ-035 SHALL cover: rst pulsed with 5 words stored and S1/S2 both valid -> rd_pvld=0 and wr_count=0 immediately; a write of 0x1234 after release is read back as the first word.
